reg_scoreboard: RTL and testbench
=================================

Name: reg_scoreboard

Overview:
- Tracks in-flight register writes between decode and writeback in the pipelined RISC-V core.
- The decode stage sets a pending mark when it issues an instruction with a destination register; writeback clears the mark.
- Flush logic clears the marks of squashed instructions.
- Produces the decode-stage stall when a source register is still pending and cannot be covered by the ID-stage writeback forward.

Parameters:
- NREG, 32, number of architectural registers; x0 is never tracked.
- REG_W, 5, register index width (log2 NREG).
- CNT_W, 2, width of the per-register outstanding-write counter; max in-flight writes per register is 2^CNT_W-1.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- issue_req  in  1  decode has a valid instruction requesting issue
- issue_rd  in  REG_W  destination of the issuing instruction
- issue_we  in  1  issuing instruction writes issue_rd
- issue_rs1  in  REG_W  source 1 (Ins_D[19:15])
- issue_rs2  in  REG_W  source 2 (Ins_D[24:20])
- use_rs1  in  1  instruction reads rs1
- use_rs2  in  1  instruction reads rs2
- wb_valid  in  1  writeback retires a register write this cycle (RegWrite_W)
- wb_rd  in  REG_W  writeback destination (rd_W)
- kill_valid  in  1  a squashed in-flight instruction's write is cancelled
- kill_rd  in  REG_W  destination of the squashed instruction
- stall_D  out  1  hold decode; instruction not issued
- issue_ack  out  1  issue_req && !stall_D
- pending  out  NREG  bit i = counter(i) != 0; bit 0 always 0
- busy_cnt  out  REG_W+1  number of registers with pending set
- err  out  1  sticky: writeback or kill on a register whose counter is 0

Behaviour:
- Reset (async, rst_n=0): all counters 0; pending=0; busy_cnt=0; err=0. stall_D and issue_ack are forced to 0 while rst_n=0. Reset mid-operation discards all marks.
- Counter update each rising clk, per register r != 0:
  - inc = issue_ack && issue_we && issue_rd==r.
  - dec = (wb_valid && wb_rd==r) + (kill_valid && kill_rd==r), giving 0..2.
  - cnt_next = cnt + inc - dec.
- Simultaneous issue and writeback to the same register: net unchanged.
- Underflow: a decrement exceeding the current count clamps cnt at 0 and sets err. err stays set until reset.
- Index 0: never incremented or decremented; writes targeting x0 are ignored and never set err.
- Source hazard for rs (rs != 0, use_rs=1): cnt(rs)!=0, except when wb_valid && wb_rd==rs && cnt(rs)==1. In that case the last write retires this cycle and is covered by ID forwarding, so there is no hazard.
- Capacity hazard: issue_we && issue_rd!=0 && cnt(issue_rd)==2^CNT_W-1 && !(wb_valid && wb_rd==issue_rd).
- stall_D = issue_req && (hazard rs1 || hazard rs2 || capacity hazard). Purely combinational from current state and inputs; zero-cycle latency.
- pending and busy_cnt are derived from registered counters. They reflect the state after the previous edge.
- Kill and writeback in the same cycle on the same register both decrement.

Decomposition:
- Package reg_scoreboard_pkg: NREG, REG_W, CNT_W defaults; typedef cnt_t (logic [CNT_W-1:0]); constant CNT_MAX.
- Sub-module sb_entry: one counter with inc/dec inputs, clamp, and underflow flag. Instantiated NREG-1 times via generate.

Test Plan:
- Reset mid-operation: issue rd=5, rd=6, then assert rst_n=0 asynchronously between edges -> pending=0, busy_cnt=0, stall_D=0 immediately.
- Load-use: issue rd=5 (we=1); next cycle issue rs1=5 with wb_valid=0 -> stall_D=1, issue_ack=0. Then wb_valid=1, wb_rd=5 -> stall_D=0 (forward covers), pending[5]=0 after the edge.
- Double in-flight: issue rd=7 twice -> cnt(7)=2. One wb rd=7 -> still stalls rs2=7 that cycle. Second wb -> no stall.
- Capacity (CNT_W=2): three issues to rd=3 -> fourth issue to rd=3 stalls. Same cycle with wb_rd=3 -> accepted, cnt stays 3.
- Kill and writeback same cycle, rd=9 cnt=2 -> cnt=0, err=0. Additional wb rd=9 -> err=1 and sticky.
- x0: issue rd=0 and rs1=0 repeatedly; wb_rd=0 -> no stall, pending[0]=0, err=0.

Source files
------------

// File: rtl/reg_scoreboard_pkg.sv
// Shared sizing for the register scoreboard: register count, index width and
// per-register outstanding-write counter width.
package reg_scoreboard_pkg;

  localparam int NREG  = 32;
  localparam int REG_W = 5;
  localparam int CNT_W = 2;

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t CNT_MAX = '1;

endpackage

// File: rtl/reg_scoreboard_sb_entry.sv
// One register's outstanding-write counter: +1 on issue, -0..2 on retire/kill,
// clamped at zero with a one-cycle underflow indication.
module sb_entry
  import reg_scoreboard_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc,
  input  logic [1:0] dec,
  output cnt_t       cnt,
  output logic       underflow
);

  localparam int SW = CNT_W + 1;

  cnt_t          cnt_q, cnt_d;
  logic [SW-1:0] sum;
  logic [SW-1:0] diff;

  // Widen before subtracting so a decrement past zero is detectable.
  always_comb begin
    sum       = {1'b0, cnt_q} + SW'(inc);
    diff      = '0;
    cnt_d     = cnt_q;
    underflow = 1'b0;
    if (SW'(dec) > sum) begin
      cnt_d     = '0;
      underflow = 1'b1;
    end else begin
      diff  = sum - SW'(dec);
      cnt_d = diff[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/reg_scoreboard.sv
// Decode-stage register scoreboard: counts in-flight writes per register and
// raises stall_D on source or counter-capacity hazards not covered by forwarding.
module reg_scoreboard
  import reg_scoreboard_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             issue_req,
  input  logic [REG_W-1:0] issue_rd,
  input  logic             issue_we,
  input  logic [REG_W-1:0] issue_rs1,
  input  logic [REG_W-1:0] issue_rs2,
  input  logic             use_rs1,
  input  logic             use_rs2,
  input  logic             wb_valid,
  input  logic [REG_W-1:0] wb_rd,
  input  logic             kill_valid,
  input  logic [REG_W-1:0] kill_rd,
  output logic             stall_D,
  output logic             issue_ack,
  output logic [NREG-1:0]  pending,
  output logic [REG_W:0]   busy_cnt,
  output logic             err
);

  logic [NREG-1:0][CNT_W-1:0] cnt_all;
  logic [NREG-1:0]            uf_all;
  logic                       err_q, err_d;
  cnt_t                       cnt_rs1, cnt_rs2, cnt_rd;
  logic                       haz_rs1, haz_rs2, haz_cap;

  assign cnt_all[0] = '0;
  assign uf_all[0]  = 1'b0;

  // x0 has no entry, so it can never stall, count or underflow.
  for (genvar r = 1; r < NREG; r++) begin : g_entry
    logic       inc;
    logic [1:0] dec;

    always_comb begin
      inc = issue_ack && issue_we && (issue_rd == REG_W'(r));
      dec = {1'b0, (wb_valid && (wb_rd == REG_W'(r)))}
          + {1'b0, (kill_valid && (kill_rd == REG_W'(r)))};
    end

    sb_entry u_entry (
      .clk       (clk),
      .rst_n     (rst_n),
      .inc       (inc),
      .dec       (dec),
      .cnt       (cnt_all[r]),
      .underflow (uf_all[r])
    );
  end

  // A source whose only outstanding write retires this cycle is forwarded in ID.
  always_comb begin
    cnt_rs1 = cnt_all[issue_rs1];
    cnt_rs2 = cnt_all[issue_rs2];
    cnt_rd  = cnt_all[issue_rd];
    haz_rs1 = use_rs1 && (issue_rs1 != '0) && (cnt_rs1 != '0)
           && !(wb_valid && (wb_rd == issue_rs1) && (cnt_rs1 == cnt_t'(1)));
    haz_rs2 = use_rs2 && (issue_rs2 != '0) && (cnt_rs2 != '0)
           && !(wb_valid && (wb_rd == issue_rs2) && (cnt_rs2 == cnt_t'(1)));
    haz_cap = issue_we && (issue_rd != '0) && (cnt_rd == CNT_MAX)
           && !(wb_valid && (wb_rd == issue_rd));
    stall_D   = rst_n && issue_req && (haz_rs1 || haz_rs2 || haz_cap);
    issue_ack = rst_n && issue_req && !stall_D;
  end

  always_comb begin
    pending  = '0;
    busy_cnt = '0;
    for (int r = 0; r < NREG; r++) begin
      pending[r] = (cnt_all[r] != '0);
      busy_cnt   = busy_cnt + (REG_W+1)'(pending[r]);
    end
  end

  assign err_d = err_q | (|uf_all);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: an integer-count model checked every
// cycle, plus literal expectations at the interesting points of each scenario.
module tb_reg_scoreboard;
  import reg_scoreboard_pkg::*;

  localparam int MAXC = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             issue_req = 1'b0;
  logic [REG_W-1:0] issue_rd = '0;
  logic             issue_we = 1'b0;
  logic [REG_W-1:0] issue_rs1 = '0;
  logic [REG_W-1:0] issue_rs2 = '0;
  logic             use_rs1 = 1'b0;
  logic             use_rs2 = 1'b0;
  logic             wb_valid = 1'b0;
  logic [REG_W-1:0] wb_rd = '0;
  logic             kill_valid = 1'b0;
  logic [REG_W-1:0] kill_rd = '0;
  logic             stall_D;
  logic             issue_ack;
  logic [NREG-1:0]  pending;
  logic [REG_W:0]   busy_cnt;
  logic             err;

  int compared = 0;
  int mismatched = 0;

  int mcnt [NREG];
  bit merr = 1'b0;

  always #5 clk = ~clk;

  reg_scoreboard dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .issue_req  (issue_req),
    .issue_rd   (issue_rd),
    .issue_we   (issue_we),
    .issue_rs1  (issue_rs1),
    .issue_rs2  (issue_rs2),
    .use_rs1    (use_rs1),
    .use_rs2    (use_rs2),
    .wb_valid   (wb_valid),
    .wb_rd      (wb_rd),
    .kill_valid (kill_valid),
    .kill_rd    (kill_rd),
    .stall_D    (stall_D),
    .issue_ack  (issue_ack),
    .pending    (pending),
    .busy_cnt   (busy_cnt),
    .err        (err)
  );

  function automatic int wbHit(logic [REG_W-1:0] r);
    return (wb_valid && wb_rd == r) ? 1 : 0;
  endfunction

  function automatic bit srcHazard(logic use_rs, logic [REG_W-1:0] rs);
    if (!use_rs || rs == 0) return 1'b0;
    return (mcnt[rs] - wbHit(rs)) > 0;
  endfunction

  function automatic bit modelStall();
    bit cap;
    if (!rst_n || !issue_req) return 1'b0;
    cap = issue_we && issue_rd != 0 && (mcnt[issue_rd] - wbHit(issue_rd)) >= MAXC;
    return srcHazard(use_rs1, issue_rs1) || srcHazard(use_rs2, issue_rs2) || cap;
  endfunction

  function automatic logic [NREG-1:0] modelPending();
    logic [NREG-1:0] p = '0;
    for (int r = 1; r < NREG; r++) p[r] = (mcnt[r] != 0);
    return p;
  endfunction

  function automatic int modelBusy();
    int n = 0;
    for (int r = 1; r < NREG; r++) if (mcnt[r] != 0) n++;
    return n;
  endfunction

  task automatic checkOutput(string name, logic [63:0] act, logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: counts per register, clamped at zero, sticky error.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) mcnt[r] = 0;
      merr = 1'b0;
    end else begin
      bit ack;
      int n;
      ack = issue_req && !modelStall();
      for (int r = 1; r < NREG; r++) begin
        n = mcnt[r];
        if (ack && issue_we && issue_rd == r) n = n + 1;
        if (wb_valid && wb_rd == r) n = n - 1;
        if (kill_valid && kill_rd == r) n = n - 1;
        if (n < 0) begin
          n = 0;
          merr = 1'b1;
        end
        mcnt[r] = n;
      end
    end
  end

  always @(negedge clk) begin
    checkOutput("model stall_D", {63'd0, stall_D}, {63'd0, modelStall()});
    checkOutput("model issue_ack", {63'd0, issue_ack},
                {63'd0, (rst_n && issue_req && !modelStall())});
    checkOutput("model pending", 64'(pending), 64'(modelPending()));
    checkOutput("model busy_cnt", 64'(busy_cnt), 64'(modelBusy()));
    checkOutput("model err", {63'd0, err}, {63'd0, merr});
  end

  task automatic applyStimulus(
    input logic req, input logic we, input int rd,
    input int rs1, input logic u1, input int rs2, input logic u2,
    input logic wbv, input int wbr, input logic kv, input int kr);
    @(posedge clk);
    #2;
    issue_req  = req;
    issue_we   = we;
    issue_rd   = REG_W'(rd);
    issue_rs1  = REG_W'(rs1);
    use_rs1    = u1;
    issue_rs2  = REG_W'(rs2);
    use_rs2    = u2;
    wb_valid   = wbv;
    wb_rd      = REG_W'(wbr);
    kill_valid = kv;
    kill_rd    = REG_W'(kr);
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic issueRd(input int rd);
    applyStimulus(1, 1, rd, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic sampleNow();
    @(negedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset pending", 64'(pending), 64'd0);
    checkOutput("reset busy_cnt", 64'(busy_cnt), 64'd0);
    checkOutput("reset err", {63'd0, err}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset in the middle of traffic drops every mark immediately.
    issueRd(5);
    issueRd(6);
    applyStimulus(1, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("prereset stall_D", {63'd0, stall_D}, 64'd1);
    checkOutput("prereset busy_cnt", 64'(busy_cnt), 64'd2);
    rst_n = 1'b0;
    #1;
    checkOutput("midreset pending", 64'(pending), 64'd0);
    checkOutput("midreset busy_cnt", 64'(busy_cnt), 64'd0);
    checkOutput("midreset stall_D", {63'd0, stall_D}, 64'd0);
    checkOutput("midreset issue_ack", {63'd0, issue_ack}, 64'd0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    idle();

    // Load-use, then forwarding covers the retiring write.
    issueRd(5);
    sampleNow();
    checkOutput("lu issue ack", {63'd0, issue_ack}, 64'd1);
    applyStimulus(1, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0);
    sampleNow();
    checkOutput("lu stall_D", {63'd0, stall_D}, 64'd1);
    checkOutput("lu issue_ack", {63'd0, issue_ack}, 64'd0);
    checkOutput("lu pending", 64'(pending), 64'h20);
    applyStimulus(1, 0, 0, 5, 1, 0, 0, 1, 5, 0, 0);
    sampleNow();
    checkOutput("lu fwd stall_D", {63'd0, stall_D}, 64'd0);
    checkOutput("lu fwd issue_ack", {63'd0, issue_ack}, 64'd1);
    idle();
    sampleNow();
    checkOutput("lu retired pending", 64'(pending), 64'd0);

    // Two writes in flight: one retire is not enough to forward.
    issueRd(7);
    issueRd(7);
    applyStimulus(1, 0, 0, 0, 0, 7, 1, 1, 7, 0, 0);
    sampleNow();
    checkOutput("dbl stall_D", {63'd0, stall_D}, 64'd1);
    checkOutput("dbl busy_cnt", 64'(busy_cnt), 64'd1);
    checkOutput("dbl model cnt7", 64'(mcnt[7]), 64'd2);
    applyStimulus(1, 0, 0, 0, 0, 7, 1, 1, 7, 0, 0);
    sampleNow();
    checkOutput("dbl last stall_D", {63'd0, stall_D}, 64'd0);
    idle();
    sampleNow();
    checkOutput("dbl pending", 64'(pending), 64'd0);

    // Counter saturation on x3.
    issueRd(3);
    issueRd(3);
    issueRd(3);
    issueRd(3);
    sampleNow();
    checkOutput("cap stall_D", {63'd0, stall_D}, 64'd1);
    checkOutput("cap model cnt3", 64'(mcnt[3]), 64'd3);
    applyStimulus(1, 1, 3, 0, 0, 0, 0, 1, 3, 0, 0);
    sampleNow();
    checkOutput("cap wb stall_D", {63'd0, stall_D}, 64'd0);
    checkOutput("cap wb issue_ack", {63'd0, issue_ack}, 64'd1);
    idle();
    sampleNow();
    checkOutput("cap after pending", 64'(pending), 64'h8);
    checkOutput("cap after model cnt3", 64'(mcnt[3]), 64'd3);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0);
    idle();
    sampleNow();
    checkOutput("cap drained pending", 64'(pending), 64'd0);
    checkOutput("cap drained err", {63'd0, err}, 64'd0);

    // x0 is never tracked.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 1, 0, 0, 1, 0, 1, 1, 0, 1, 0);
      sampleNow();
      checkOutput("x0 stall_D", {63'd0, stall_D}, 64'd0);
      checkOutput("x0 issue_ack", {63'd0, issue_ack}, 64'd1);
    end
    idle();
    sampleNow();
    checkOutput("x0 pending", 64'(pending), 64'd0);
    checkOutput("x0 err", {63'd0, err}, 64'd0);

    // Kill and writeback together, then an underflowing writeback.
    issueRd(9);
    issueRd(9);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 9, 1, 9);
    idle();
    sampleNow();
    checkOutput("kill pending", 64'(pending), 64'd0);
    checkOutput("kill err", {63'd0, err}, 64'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0);
    idle();
    sampleNow();
    checkOutput("underflow err", {63'd0, err}, 64'd1);
    idle();
    idle();
    sampleNow();
    checkOutput("sticky err", {63'd0, err}, 64'd1);
    checkOutput("underflow pending", 64'(pending), 64'd0);

    rst_n = 1'b0;
    #1;
    checkOutput("reset clears err", {63'd0, err}, 64'd0);
    @(negedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
